histo_thresh_binarizer: RTL and testbench

- Downstream consumer of the histogram stage's 8-bit median threshold (threshOut).
- Latches that threshold once per frame and binarises the live 12-bit grey pixel stream against it. Emits a pipelined binary/display pixel.
- Accumulates per-frame foreground statistics: pixel count and bounding box. These are published at end of frame for the tracking/overlay logic.

---
 rtl/histo_thresh_binarizer.sv | 198 +++++++++++++++++++
 tb/tb_histo_thresh_binarizer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/histo_thresh_binarizer.sv
// Binarises the live grey stream against a per-frame latched threshold and
// publishes foreground count and bounding box at the end of every frame.
module histo_thresh_binarizer #(
  parameter int GREY_W       = 12,
  parameter int THRESH_SHIFT = 4,
  parameter int COUNT_W      = 20,
  parameter bit INVERT       = 1'b0
) (
  input  logic               iPclk,
  input  logic               iRst,
  input  logic               iFval,
  input  logic               iDval,
  input  logic [15:0]        iX_Cont,
  input  logic [15:0]        iY_Cont,
  input  logic [GREY_W-1:0]  iGrey,
  input  logic [7:0]         iThresh,
  output logic               oDval,
  output logic [15:0]        oX_Cont,
  output logic [15:0]        oY_Cont,
  output logic               oBin,
  output logic [15:0]        oBin_Grey,
  output logic [7:0]         oThreshUsed,
  output logic [COUNT_W-1:0] oFgCount,
  output logic [15:0]        oMinX,
  output logic [15:0]        oMaxX,
  output logic [15:0]        oMinY,
  output logic [15:0]        oMaxY,
  output logic               oEmpty,
  output logic               oStatsValid,
  output logic [1:0]         oDbgState
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_PUBLISH = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               fval_q, fval_d;
  logic               rise_pend_q, rise_pend_d;
  logic [7:0]         thresh_q, thresh_d;
  logic               s1_dval_q, s1_dval_d;
  logic [15:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [7:0]         s1_g8_q, s1_g8_d;
  logic               s2_dval_q, s2_dval_d;
  logic [15:0]        s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic               s2_bin_q, s2_bin_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]        min_x_q, min_x_d, max_x_q, max_x_d;
  logic [15:0]        min_y_q, min_y_d, max_y_q, max_y_d;
  logic [COUNT_W-1:0] pub_cnt_q, pub_cnt_d;
  logic [15:0]        pub_min_x_q, pub_min_x_d, pub_max_x_q, pub_max_x_d;
  logic [15:0]        pub_min_y_q, pub_min_y_d, pub_max_y_q, pub_max_y_d;
  logic               empty_q, empty_d;
  logic               stats_valid_q, stats_valid_d;

  logic rise, fall, fg, s1_fg;

  always_comb begin
    rise = iFval & ~fval_q;
    fall = ~iFval & fval_q;
    fg    = INVERT ? (s1_g8_q <= thresh_q) : (s1_g8_q > thresh_q);
    s1_fg = s1_dval_q & fg;

    state_d       = state_q;
    fval_d        = iFval;
    rise_pend_d   = rise_pend_q;
    thresh_d      = thresh_q;
    pub_cnt_d     = pub_cnt_q;
    pub_min_x_d   = pub_min_x_q;
    pub_max_x_d   = pub_max_x_q;
    pub_min_y_d   = pub_min_y_q;
    pub_max_y_d   = pub_max_y_q;
    empty_d       = empty_q;
    stats_valid_d = 1'b0;

    s1_dval_d = iDval & (state_q == S_ACTIVE);
    s1_x_d    = iX_Cont;
    s1_y_d    = iY_Cont;
    s1_g8_d   = 8'(iGrey >> THRESH_SHIFT);
    s2_dval_d = s1_dval_q;
    s2_x_d    = s1_x_q;
    s2_y_d    = s1_y_q;
    s2_bin_d  = s1_fg;

    // Accumulation happens as a pixel moves into stage 2, so the pixel in
    // flight at the falling edge is folded in before PUBLISH reads the totals.
    cnt_d   = cnt_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    if (s1_fg) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);
      if (s1_x_q < min_x_q) min_x_d = s1_x_q;
      if (s1_x_q > max_x_q) max_x_d = s1_x_q;
      if (s1_y_q < min_y_q) min_y_d = s1_y_q;
      if (s1_y_q > max_y_q) max_y_d = s1_y_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rise || rise_pend_q) begin
          thresh_d    = iThresh;
          rise_pend_d = 1'b0;
          cnt_d       = '0;
          min_x_d     = 16'hFFFF;
          min_y_d     = 16'hFFFF;
          max_x_d     = 16'h0000;
          max_y_d     = 16'h0000;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (fall) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        rise_pend_d   = rise;
        stats_valid_d = 1'b1;
        pub_cnt_d     = cnt_q;
        empty_d       = (cnt_q == '0);
        pub_min_x_d   = (cnt_q == '0) ? 16'h0000 : min_x_q;
        pub_max_x_d   = (cnt_q == '0) ? 16'h0000 : max_x_q;
        pub_min_y_d   = (cnt_q == '0) ? 16'h0000 : min_y_q;
        pub_max_y_d   = (cnt_q == '0) ? 16'h0000 : max_y_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      state_q       <= S_IDLE;
      fval_q        <= 1'b1;
      rise_pend_q   <= 1'b0;
      thresh_q      <= '0;
      s1_dval_q     <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_g8_q       <= '0;
      s2_dval_q     <= 1'b0;
      s2_x_q        <= '0;
      s2_y_q        <= '0;
      s2_bin_q      <= 1'b0;
      cnt_q         <= '0;
      min_x_q       <= '0;
      max_x_q       <= '0;
      min_y_q       <= '0;
      max_y_q       <= '0;
      pub_cnt_q     <= '0;
      pub_min_x_q   <= '0;
      pub_max_x_q   <= '0;
      pub_min_y_q   <= '0;
      pub_max_y_q   <= '0;
      empty_q       <= 1'b1;
      stats_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fval_q        <= fval_d;
      rise_pend_q   <= rise_pend_d;
      thresh_q      <= thresh_d;
      s1_dval_q     <= s1_dval_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      s1_g8_q       <= s1_g8_d;
      s2_dval_q     <= s2_dval_d;
      s2_x_q        <= s2_x_d;
      s2_y_q        <= s2_y_d;
      s2_bin_q      <= s2_bin_d;
      cnt_q         <= cnt_d;
      min_x_q       <= min_x_d;
      max_x_q       <= max_x_d;
      min_y_q       <= min_y_d;
      max_y_q       <= max_y_d;
      pub_cnt_q     <= pub_cnt_d;
      pub_min_x_q   <= pub_min_x_d;
      pub_max_x_q   <= pub_max_x_d;
      pub_min_y_q   <= pub_min_y_d;
      pub_max_y_q   <= pub_max_y_d;
      empty_q       <= empty_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign oDval       = s2_dval_q;
  assign oX_Cont     = s2_x_q;
  assign oY_Cont     = s2_y_q;
  assign oBin        = s2_bin_q;
  assign oBin_Grey   = {16{s2_bin_q}};
  assign oThreshUsed = thresh_q;
  assign oFgCount    = pub_cnt_q;
  assign oMinX       = pub_min_x_q;
  assign oMaxX       = pub_max_x_q;
  assign oMinY       = pub_min_y_q;
  assign oMaxY       = pub_max_y_q;
  assign oEmpty      = empty_q;
  assign oStatsValid = stats_valid_q;
  assign oDbgState   = state_q;

endmodule

// File: tb/tb_histo_thresh_binarizer.sv
// Directed frame table for histo_thresh_binarizer: per-pixel scoreboard on the
// 2-cycle output plus end-of-frame statistics on normal, inverted and 4-bit-count variants.
module tb_histo_thresh_binarizer;

  localparam int SB_W = 65;

  logic        clk = 1'b0;
  logic        iRst, iFval, iDval;
  logic [15:0] iX_Cont, iY_Cont;
  logic [11:0] iGrey;
  logic [7:0]  iThresh;

  logic        a_dval, a_bin, a_empty, a_sv;
  logic [15:0] a_x, a_y, a_bgrey, a_minx, a_maxx, a_miny, a_maxy;
  logic [7:0]  a_th;
  logic [19:0] a_cnt;
  logic [1:0]  a_st;

  logic        b_dval, b_bin, b_empty, b_sv;
  logic [15:0] b_x, b_y, b_bgrey, b_minx, b_maxx, b_miny, b_maxy;
  logic [7:0]  b_th;
  logic [19:0] b_cnt;
  logic [1:0]  b_st;

  logic        c_dval, c_bin, c_empty, c_sv;
  logic [15:0] c_x, c_y, c_bgrey, c_minx, c_maxx, c_miny, c_maxy;
  logic [7:0]  c_th;
  logic [3:0]  c_cnt;
  logic [1:0]  c_st;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  logic [SB_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  histo_thresh_binarizer dut_a (
    .iPclk(clk), .iRst(iRst), .iFval(iFval), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iGrey(iGrey), .iThresh(iThresh),
    .oDval(a_dval), .oX_Cont(a_x), .oY_Cont(a_y), .oBin(a_bin), .oBin_Grey(a_bgrey),
    .oThreshUsed(a_th), .oFgCount(a_cnt), .oMinX(a_minx), .oMaxX(a_maxx),
    .oMinY(a_miny), .oMaxY(a_maxy), .oEmpty(a_empty), .oStatsValid(a_sv),
    .oDbgState(a_st));

  histo_thresh_binarizer #(.INVERT(1'b1)) dut_b (
    .iPclk(clk), .iRst(iRst), .iFval(iFval), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iGrey(iGrey), .iThresh(iThresh),
    .oDval(b_dval), .oX_Cont(b_x), .oY_Cont(b_y), .oBin(b_bin), .oBin_Grey(b_bgrey),
    .oThreshUsed(b_th), .oFgCount(b_cnt), .oMinX(b_minx), .oMaxX(b_maxx),
    .oMinY(b_miny), .oMaxY(b_maxy), .oEmpty(b_empty), .oStatsValid(b_sv),
    .oDbgState(b_st));

  histo_thresh_binarizer #(.COUNT_W(4)) dut_c (
    .iPclk(clk), .iRst(iRst), .iFval(iFval), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iGrey(iGrey), .iThresh(iThresh),
    .oDval(c_dval), .oX_Cont(c_x), .oY_Cont(c_y), .oBin(c_bin), .oBin_Grey(c_bgrey),
    .oThreshUsed(c_th), .oFgCount(c_cnt), .oMinX(c_minx), .oMaxX(c_maxx),
    .oMinY(c_miny), .oMaxY(c_maxy), .oEmpty(c_empty), .oStatsValid(c_sv),
    .oDbgState(c_st));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: each entry is {output cycle, bin, x, y}
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (a_sv) pulses++;
    if (exp_q.size() > 0 && exp_q[0][64:33] == 32'(cyc)) begin
      e = exp_q.pop_front();
      chk("pix_dval", 32'(a_dval), 32'd1);
      chk("pix_bin", 32'(a_bin), 32'(e[32]));
      chk("pix_bin_grey", 32'(a_bgrey), e[32] ? 32'hFFFF : 32'h0);
      chk("pix_x", 32'(a_x), 32'(e[31:16]));
      chk("pix_y", 32'(a_y), 32'(e[15:0]));
    end else if (a_dval) begin
      chk("unexpected_dval", 32'(a_dval), 32'd0);
    end
  end

  typedef struct {
    int w; int h;
    logic [7:0] th0; logic [7:0] th1;
    logic [11:0] bg; logic [11:0] fg;
    int fx; int fy;
    int exp_cnt;
    logic [15:0] minx; logic [15:0] maxx; logic [15:0] miny; logic [15:0] maxy;
    logic exp_empty;
    int exp_inv_cnt;
    int exp_sat_cnt;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      iFval = 1'b0; iDval = 1'b0;
    end
  endtask

  task automatic push_pixel(input int x, input int y, input logic [11:0] g, input logic [7:0] th);
    logic [7:0] g8;
    g8 = g[11:4];
    exp_q.push_back({32'(cyc + 2), (g8 > th), 16'(x), 16'(y)});
  endtask

  // driver: rise cycle, w*h back-to-back pixels, fall, then wait for the publish
  task automatic run_frame(input int id, input frame_vec_t v);
    int idx, n, p0;
    logic got;
    logic [11:0] g;
    p0 = pulses;
    @(posedge clk); #1;
    iFval = 1'b1; iDval = 1'b0; iThresh = v.th0;
    idx = 0;
    for (int y = 0; y < v.h; y++) begin
      for (int x = 0; x < v.w; x++) begin
        @(posedge clk); #1;
        g = (x == v.fx && y == v.fy) ? v.fg : v.bg;
        iDval = 1'b1; iX_Cont = 16'(x); iY_Cont = 16'(y); iGrey = g;
        if (idx == 6) iThresh = v.th1;
        push_pixel(x, y, g, v.th0);
        idx++;
      end
    end
    @(posedge clk); #1;
    iFval = 1'b0; iDval = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (a_sv) got = 1'b1;
      n++;
    end
    chk($sformatf("f%0d_stats_pulse", id), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("f%0d_cnt", id), 32'(a_cnt), 32'(v.exp_cnt));
      chk($sformatf("f%0d_minx", id), 32'(a_minx), 32'(v.minx));
      chk($sformatf("f%0d_maxx", id), 32'(a_maxx), 32'(v.maxx));
      chk($sformatf("f%0d_miny", id), 32'(a_miny), 32'(v.miny));
      chk($sformatf("f%0d_maxy", id), 32'(a_maxy), 32'(v.maxy));
      chk($sformatf("f%0d_empty", id), 32'(a_empty), 32'(v.exp_empty));
      chk($sformatf("f%0d_inv_cnt", id), 32'(b_cnt), 32'(v.exp_inv_cnt));
      chk($sformatf("f%0d_inv_empty", id), 32'(b_empty), 32'(v.exp_inv_cnt == 0));
      chk($sformatf("f%0d_sat_cnt", id), 32'(c_cnt), 32'(v.exp_sat_cnt));
    end
    chk($sformatf("f%0d_thresh_used", id), 32'(a_th), 32'(v.th0));
    idle_cycles(5);
    @(negedge clk);
    chk($sformatf("f%0d_pulse_count", id), 32'(pulses - p0), 32'd1);
    chk($sformatf("f%0d_queue_drained", id), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{4, 4, 8'h80, 8'h80, 12'h900, 12'h900, -1, -1, 16, 16'd0, 16'd3, 16'd0, 16'd3, 1'b0, 0, 15};
    vecs[1] = '{4, 4, 8'h80, 8'h80, 12'h800, 12'h800, -1, -1, 0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 16, 0};
    vecs[2] = '{3, 2, 8'h80, 8'h80, 12'h000, 12'hFFF, 2, 1, 1, 16'd2, 16'd2, 16'd1, 16'd1, 1'b0, 5, 1};
    vecs[3] = '{4, 4, 8'h80, 8'h10, 12'h500, 12'h500, -1, -1, 0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 16, 0};
    vecs[4] = '{4, 4, 8'h10, 8'h10, 12'h500, 12'h500, -1, -1, 16, 16'd0, 16'd3, 16'd0, 16'd3, 1'b0, 0, 15};
    vecs[5] = '{5, 4, 8'h80, 8'h80, 12'h900, 12'h900, -1, -1, 20, 16'd0, 16'd4, 16'd0, 16'd3, 1'b0, 0, 15};

    iRst = 1'b1; iFval = 1'b0; iDval = 1'b0;
    iX_Cont = '0; iY_Cont = '0; iGrey = '0; iThresh = '0;
    repeat (3) @(posedge clk);
    #1 iRst = 1'b0;
    @(negedge clk);
    chk("rst_dval", 32'(a_dval), 32'd0);
    chk("rst_bin_grey", 32'(a_bgrey), 32'd0);
    chk("rst_thresh", 32'(a_th), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_maxx", 32'(a_maxx), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_stats_valid", 32'(a_sv), 32'd0);
    chk("rst_state", 32'(a_st), 32'd0);
    idle_cycles(2);

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // reset in mid-frame, released with the frame still running
    p0 = pulses;
    @(posedge clk); #1;
    iFval = 1'b1; iDval = 1'b0; iThresh = 8'h80;
    for (int x = 0; x < 3; x++) begin
      @(posedge clk); #1;
      iDval = 1'b1; iX_Cont = 16'(x); iY_Cont = 16'd0; iGrey = 12'h900;
      push_pixel(x, 0, 12'h900, 8'h80);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      iDval = 1'b0;
    end
    iRst = 1'b1;
    @(posedge clk); #1;
    iRst = 1'b0;
    for (int x = 0; x < 6; x++) begin
      @(posedge clk); #1;
      iDval = 1'b1; iX_Cont = 16'(x); iY_Cont = 16'd1; iGrey = 12'h900;
    end
    idle_cycles(10);
    @(negedge clk);
    chk("rstmid_no_pulse", 32'(pulses - p0), 32'd0);
    chk("rstmid_cnt", 32'(a_cnt), 32'd0);
    chk("rstmid_empty", 32'(a_empty), 32'd1);
    chk("rstmid_thresh", 32'(a_th), 32'd0);
    chk("rstmid_maxy", 32'(a_maxy), 32'd0);
    chk("rstmid_state", 32'(a_st), 32'd0);

    run_frame(6, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
